// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-stage bus between the fetch unit, instruction memory and decode
interface inst_fetch_if;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] rom_data_i;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    modport master (
        input  stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_i, rom_data_i,
        output rom_addr_o, rom_ce_o, if_pc_o, if_inst_o, if_valid_o
    );
    modport slave (
        output stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_i, rom_data_i,
        input  rom_addr_o, rom_ce_o, if_pc_o, if_inst_o, if_valid_o
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: program counter, instruction fetch and IF/ID pipeline register
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input logic clk,
    input logic rst,
    inst_fetch_if.master bus
);
    logic        ce_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        squash;
    assign bus.rom_addr_o = pc_q;
    assign bus.rom_ce_o   = ce_q;
    assign squash = bus.branch_flag_i && !DELAY_SLOT;
    // next PC: enable-up holds RESET_PC, then flush > stall > branch > sequential
    always_comb begin
        pc_d = !ce_q            ? RESET_PC :
               bus.flush_i      ? {bus.flush_pc_i[31:2], 2'b00} :
               bus.stall_i      ? pc_q :
               bus.branch_flag_i ? {bus.branch_target_i[31:2], 2'b00} :
                                   pc_q + 32'd4;
    end
    // PC and chip-enable registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q <= 1'b0;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= 1'b1;
            pc_q <= pc_d;
        end
    end
    // IF/ID register: flush clears, stall holds, squashed branch shadow clears
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i || (!bus.stall_i && squash)) begin
            bus.if_pc_o    <= '0;
            bus.if_inst_o  <= '0;
            bus.if_valid_o <= 1'b0;
        end else if (!bus.stall_i) begin
            bus.if_pc_o    <= pc_q;
            bus.if_inst_o  <= bus.rom_data_i;
            bus.if_valid_o <= ce_q;
        end
    end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

- Front end of the five-stage pipeline: owns the program counter and drives the fetch side of the combinational instruction memory (`rom_addr_o`, `rom_ce_o`).
- Captures the returned word plus its PC into the IF/ID pipeline register.
- Supports stall, branch redirect (with optional delay slot) and pipeline flush.
- Sits between the instruction memory and the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DELAY_SLOT, 1, 1 = instruction after a branch is kept; 0 = it is squashed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold PC and IF/ID contents.
- flush_i  input  1  squash IF/ID and redirect to flush_pc_i.
- flush_pc_i  input  32  redirect address on flush.
- branch_flag_i  input  1  taken branch from decode.
- branch_target_i  input  32  branch destination.
- rom_data_i  input  32  instruction word from memory; combinational in rom_addr_o.
- rom_addr_o  output  32  fetch address (equals PC).
- rom_ce_o  output  1  memory chip enable; memory returns zero when low.
- if_pc_o  output  32  IF/ID registered PC.
- if_inst_o  output  32  IF/ID registered instruction.
- if_valid_o  output  1  IF/ID holds a real instruction.

## Operation

- Registers: `ce_q`, `pc_q`, `if_pc_o`, `if_inst_o`, `if_valid_o`.
- `rom_addr_o = pc_q`; `rom_ce_o = ce_q`.
- Next-PC priority, evaluated each edge (highest first):
  - rst: ce_q=0, pc_q=RESET_PC, IF/ID cleared.
  - ce_q==0: ce_q<=1, pc_q holds RESET_PC.
  - flush_i: pc_q<=flush_pc_i.
  - stall_i: pc_q holds.
  - branch_flag_i: pc_q<=branch_target_i.
  - otherwise: pc_q<=pc_q+4.
- IF/ID update, same priority:
  - rst or flush_i: if_pc_o=0, if_inst_o=0, if_valid_o=0.
  - stall_i: hold all three.
  - branch_flag_i with DELAY_SLOT=0: clear (squash the word fetched this cycle).
  - otherwise: if_pc_o<=pc_q, if_inst_o<=rom_data_i, if_valid_o<=ce_q.
- Address arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Alignment: bits [1:0] of branch_target_i and flush_pc_i are forced to 0 before loading pc_q.
- Branch during stall is ignored. Decode keeps branch_flag_i asserted until a non-stalled cycle, so the redirect is taken then.
- Flush overrides stall and branch in the same cycle.

## Timing

- Reset values: rom_ce_o=0, rom_addr_o=RESET_PC, if_pc_o=0, if_inst_o=0, if_valid_o=0.
- Edge 1 after rst falls: rom_ce_o=1, rom_addr_o=RESET_PC.
- Edge 2: IF/ID holds (RESET_PC, mem[RESET_PC], valid=1); rom_addr_o=RESET_PC+4.
- Fetch latency: 1 cycle from address presentation to IF/ID.
- Throughput: 1 instruction/cycle when not stalled.
- Branch: target appears on rom_addr_o 1 edge after branch_flag_i is sampled; its instruction reaches IF/ID 1 edge later.
- Flush: IF/ID invalid on the next edge; instruction at flush_pc_i valid in IF/ID 2 edges after flush_i is sampled.
- Stall: outputs frozen for exactly the cycles stall_i is high.
- rst asserted mid-stream: all state takes reset values on the next edge regardless of stall/flush/branch.

## Test plan

- Reset then run, memory = {0:3401_1100, 4:3402_0020, 8:3403_FF00, C:3404_FFFF} -> IF/ID sequence (0,34011100), (4,34020020), (8,3403FF00), (C,3404FFFF), then (10,00000000) valid=1.
- stall_i high 3 cycles while IF/ID=(4,34020020) -> IF/ID and rom_addr_o=8 unchanged for 3 cycles; fetching resumes at 8.
- branch_flag_i=1, target 32'h0000_0002 while PC=4:
  - DELAY_SLOT=1 -> IF/ID (4,…) then (0,34011100).
  - DELAY_SLOT=0 -> IF/ID invalid, then (0,…).
- flush_i, stall_i and branch_flag_i all high together, flush_pc_i=C -> rom_addr_o=C next edge; if_valid_o=0; (C,3404FFFF) valid after one more edge.
- RESET_PC=32'hFFFF_FFF8 -> rom_addr_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulsed for one cycle mid-stream with PC=8 -> rom_ce_o=0 and if_valid_o=0 next edge; restart at RESET_PC per the reset sequence.
